// File: rtl/boss_attack_sequencer_pkg.sv
// Shared types and constants for the boss attack sequencer: phase and pattern
// encodings plus the 8-lane volley masks.
package boss_attack_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_INTRO   = 3'd0,
    PH_NORMAL  = 3'd1,
    PH_ENRAGED = 3'd2,
    PH_DYING   = 3'd3,
    PH_DONE    = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    PAT_FAN       = 2'd0,
    PAT_ALTERNATE = 2'd1,
    PAT_SWEEP     = 2'd2
  } pattern_e;

  localparam logic [7:0] MASK_FAN  = 8'hFF;
  localparam logic [7:0] MASK_EVEN = 8'h55;
  localparam logic [7:0] MASK_ODD  = 8'hAA;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/boss_attack_sequencer_frame_counter.sv
// Tick-driven loadable frame counter; expire pulses combinationally on the
// tick that is the Nth one after the most recent load.
module boss_attack_sequencer_frame_counter #(
  parameter int WIDTH       = 8,
  parameter int INIT_TARGET = 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] target;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count  <= '0;
      target <= WIDTH'(INIT_TARGET);
    end else if (load) begin
      count  <= '0;
      target <= load_value;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  assign expire = tick && ((count + 1'b1) == target);

endmodule

// File: rtl/boss_attack_sequencer.sv
// Frame-driven boss attack scheduler: phase progression, cooldown/burst timing,
// per-volley lane masks and direction-switch pulses.
module boss_attack_sequencer
  import boss_attack_sequencer_pkg::*;
#(
  parameter int LANE_COUNT             = 8,
  parameter int LIVES_WIDTH            = 5,
  parameter int INTRO_FRAMES           = 60,
  parameter int COOLDOWN_FRAMES        = 90,
  parameter int ENRAGE_COOLDOWN_FRAMES = 45,
  parameter int BURST_GAP_FRAMES       = 6,
  parameter int ENRAGE_LIVES           = 1,
  parameter int DEATH_FRAMES           = 10
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   enable,
  input  logic                   startOfFrame,
  input  logic [LIVES_WIDTH-1:0] lives_left,
  input  logic                   boss_dead,
  output logic [LANE_COUNT-1:0]  lane_fire,
  output logic                   direction_switch,
  output logic [2:0]             phase,
  output logic                   attack_busy,
  output logic                   encounter_done
);

  localparam int CW = $clog2(max_int(max_int(max_int(INTRO_FRAMES, COOLDOWN_FRAMES),
                             max_int(ENRAGE_COOLDOWN_FRAMES, BURST_GAP_FRAMES)),
                             DEATH_FRAMES)) + 1;
  localparam int VW        = (LANE_COUNT > 2) ? $clog2(LANE_COUNT) : 1;
  localparam int MASK_REPS = (LANE_COUNT + 7) / 8;

  function automatic logic [LANE_COUNT-1:0] volley_mask(input pattern_e p,
                                                        input logic [VW-1:0] v);
    case (p)
      PAT_FAN:       return LANE_COUNT'({MASK_REPS{MASK_FAN}});
      PAT_ALTERNATE: return v[0] ? LANE_COUNT'({MASK_REPS{MASK_ODD}})
                                 : LANE_COUNT'({MASK_REPS{MASK_EVEN}});
      default:       return LANE_COUNT'(1) << v;
    endcase
  endfunction

  function automatic int volley_total(input pattern_e p);
    case (p)
      PAT_FAN:       return 1;
      PAT_ALTERNATE: return 2;
      default:       return LANE_COUNT;
    endcase
  endfunction

  // NORMAL cycles FAN/ALTERNATE; ENRAGED adds SWEEP to the rotation.
  function automatic pattern_e next_pattern(input pattern_e p, input logic enraged);
    case (p)
      PAT_FAN:       return PAT_ALTERNATE;
      PAT_ALTERNATE: return enraged ? PAT_SWEEP : PAT_FAN;
      default:       return PAT_FAN;
    endcase
  endfunction

  phase_e                phase_q, phase_d;
  pattern_e              pat_q, pat_d;
  logic                  burst_q, burst_d;
  logic [VW-1:0]         volley_q, volley_d;
  logic [LANE_COUNT-1:0] fire_d;
  logic                  dir_d;
  logic [VW-1:0]         v;
  logic                  main_load, gap_load, main_expire, gap_expire;
  logic [CW-1:0]         main_value;

  logic tick;
  logic enrage;
  assign tick   = startOfFrame & enable;
  assign enrage = (lives_left != '0) && (lives_left <= LIVES_WIDTH'(ENRAGE_LIVES));

  boss_attack_sequencer_frame_counter #(.WIDTH(CW), .INIT_TARGET(INTRO_FRAMES)) u_main_ctr (
    .clk(clk), .resetN(resetN), .tick(tick), .load(main_load),
    .load_value(main_value), .expire(main_expire)
  );

  boss_attack_sequencer_frame_counter #(.WIDTH(CW), .INIT_TARGET(BURST_GAP_FRAMES)) u_gap_ctr (
    .clk(clk), .resetN(resetN), .tick(tick), .load(gap_load),
    .load_value(CW'(BURST_GAP_FRAMES)), .expire(gap_expire)
  );

  // NOTE: every always_comb output gets a default first so no path holds a
  // stale value, which would infer a latch.
  always_comb begin
    phase_d    = phase_q;
    pat_d      = pat_q;
    burst_d    = burst_q;
    volley_d   = volley_q;
    fire_d     = '0;
    dir_d      = 1'b0;
    v          = '0;
    main_load  = 1'b0;
    gap_load   = 1'b0;
    main_value = CW'(COOLDOWN_FRAMES);

    if (tick) begin
      unique case (phase_q)
        PH_INTRO, PH_NORMAL, PH_ENRAGED: begin
          if (boss_dead) begin
            phase_d    = PH_DYING;
            burst_d    = 1'b0;
            main_load  = 1'b1;
            main_value = CW'(DEATH_FRAMES);
          end else if (phase_q == PH_INTRO) begin
            if (main_expire) begin
              phase_d   = PH_NORMAL;
              pat_d     = PAT_FAN;
              main_load = 1'b1;
            end
          end else if (phase_q == PH_NORMAL && enrage) begin
            phase_d    = PH_ENRAGED;
            burst_d    = 1'b0;
            pat_d      = PAT_FAN;
            main_load  = 1'b1;
            main_value = CW'(ENRAGE_COOLDOWN_FRAMES);
          end else if (burst_q ? gap_expire : main_expire) begin
            v      = burst_q ? volley_q : '0;
            fire_d = volley_mask(pat_q, v);
            dir_d  = !burst_q;
            if (int'(v) == volley_total(pat_q) - 1) begin
              burst_d    = 1'b0;
              pat_d      = next_pattern(pat_q, phase_q == PH_ENRAGED);
              main_load  = 1'b1;
              main_value = (phase_q == PH_ENRAGED) ? CW'(ENRAGE_COOLDOWN_FRAMES)
                                                   : CW'(COOLDOWN_FRAMES);
            end else begin
              burst_d  = 1'b1;
              volley_d = v + 1'b1;
              gap_load = 1'b1;
            end
          end
        end
        PH_DYING: if (main_expire) phase_d = PH_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      phase_q          <= PH_INTRO;
      pat_q            <= PAT_FAN;
      burst_q          <= 1'b0;
      volley_q         <= '0;
      lane_fire        <= '0;
      direction_switch <= 1'b0;
      encounter_done   <= 1'b0;
    end else begin
      phase_q          <= phase_d;
      pat_q            <= pat_d;
      burst_q          <= burst_d;
      volley_q         <= volley_d;
      lane_fire        <= fire_d;
      direction_switch <= dir_d;
      encounter_done   <= (phase_d == PH_DONE);
    end
  end

  assign phase       = phase_q;
  assign attack_busy = burst_q;

endmodule

// File: tb/tb_boss_attack_sequencer.sv
// Self-checking bench: per-frame expectations from tick-indexed tables feed a
// scoreboard queue; hand sequences cover enable freeze, reset and death.
module tb_boss_attack_sequencer;

  logic       clk = 1'b0, resetN = 1'b1, enable = 1'b0, startOfFrame = 1'b0, boss_dead = 1'b0;
  logic [4:0] lives_left = 5'd3;
  logic [7:0] lane_fire;
  logic       direction_switch, attack_busy, encounter_done;
  logic [2:0] phase;

  always #5 clk = ~clk;

  boss_attack_sequencer #(
    .LANE_COUNT(8), .LIVES_WIDTH(5), .INTRO_FRAMES(60), .COOLDOWN_FRAMES(90),
    .ENRAGE_COOLDOWN_FRAMES(45), .BURST_GAP_FRAMES(6), .ENRAGE_LIVES(1), .DEATH_FRAMES(10)
  ) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(startOfFrame),
    .lives_left(lives_left), .boss_dead(boss_dead), .lane_fire(lane_fire),
    .direction_switch(direction_switch), .phase(phase), .attack_busy(attack_busy),
    .encounter_done(encounter_done)
  );

  typedef struct { int tick; int lives; bit dead; logic [7:0] lanes; bit dir; int ph; } vec_t;
  typedef struct { logic [7:0] lanes; bit dir; logic [2:0] ph; } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_tests = 0, n_fail = 0, fc = 0, cur_ph = 0, dir_seen = 0, exp_attacks = 0;
  bit   prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int t, input int lv, input bit dd, input logic [7:0] l,
                     input bit d, input int ph);
    tbl.push_back('{t, lv, dd, l, d, ph});
  endtask

  // One frame: tick pulse for one clk, sample on the negedge after the tick edge.
  task automatic frame(input bit en);
    @(negedge clk);
    if (prev_pulse) check("pulse_width", {23'b0, direction_switch, lane_fire}, 32'd0);
    enable       = en;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    prev_pulse   = (lane_fire != 8'h00) || direction_switch;
    if (direction_switch) dir_seen++;
  endtask

  task automatic step(input bit en, input logic [7:0] l, input bit d);
    exp_t e;
    sb.push_back('{l, d, 3'(cur_ph)});
    frame(en);
    e = sb.pop_front();
    check($sformatf("lane_fire@%0d", fc), 32'(lane_fire), 32'(e.lanes));
    check($sformatf("direction_switch@%0d", fc), 32'(direction_switch), 32'(e.dir));
    check($sformatf("phase@%0d", fc), 32'(phase), 32'(e.ph));
  endtask

  task automatic run_table(input int last);
    for (int t = fc + 1; t <= last; t++) begin
      logic [7:0] l;
      bit d;
      l  = 8'h00;
      d  = 1'b0;
      fc = t;
      foreach (tbl[i]) begin
        if (tbl[i].tick == t) begin
          lives_left = 5'(tbl[i].lives);
          boss_dead  = tbl[i].dead;
          cur_ph     = tbl[i].ph;
          l          = tbl[i].lanes;
          d          = tbl[i].dir;
        end
      end
      step(1'b1, l, d);
    end
  endtask

  // Asserts reset between clock edges so only the asynchronous path can clear outputs.
  task automatic do_reset(input int lv);
    #2 resetN = 1'b0;
    #1;
    check("rst_lane_fire", 32'(lane_fire), 32'd0);
    check("rst_direction_switch", 32'(direction_switch), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_attack_busy", 32'(attack_busy), 32'd0);
    check("rst_encounter_done", 32'(encounter_done), 32'd0);
    startOfFrame = 1'b0;
    enable       = 1'b1;
    boss_dead    = 1'b0;
    lives_left   = 5'(lv);
    @(negedge clk);
    @(negedge clk);
    resetN     = 1'b1;
    fc         = 0;
    cur_ph     = 0;
    prev_pulse = 1'b0;
    tbl.delete();
  endtask

  task automatic load_intro_rows();
    add(60,  3, 0, 8'h00, 0, 1);
    add(150, 3, 0, 8'hFF, 1, 1);
    add(240, 3, 0, 8'h55, 1, 1);
    add(246, 3, 0, 8'hAA, 0, 1);
  endtask

  initial begin
    // Normal cadence, enrage mid-ALTERNATE, ENRAGED rotation, death on cooldown expiry.
    do_reset(3);
    load_intro_rows();
    add(336, 3, 0, 8'hFF, 1, 1);
    add(426, 3, 0, 8'h55, 1, 1);
    add(432, 3, 0, 8'hAA, 0, 1);
    add(522, 3, 0, 8'hFF, 1, 1);
    add(612, 3, 0, 8'h55, 1, 1);
    add(615, 1, 0, 8'h00, 0, 2);
    add(660, 1, 0, 8'hFF, 1, 2);
    add(705, 1, 0, 8'h55, 1, 2);
    add(711, 1, 0, 8'hAA, 0, 2);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] m;
      m = 8'h01 << k;
      add(756 + 6 * k, 1, 0, m, k == 0, 2);
    end
    add(843, 1, 0, 8'hFF, 1, 2);
    add(888, 1, 1, 8'h00, 0, 3);
    add(898, 1, 1, 8'h00, 0, 4);
    run_table(613);
    check("busy_mid_alternate", 32'(attack_busy), 32'd1);
    run_table(615);
    check("busy_after_enrage", 32'(attack_busy), 32'd0);
    run_table(760);
    check("busy_mid_sweep", 32'(attack_busy), 32'd1);
    run_table(897);
    check("done_before_death_end", 32'(encounter_done), 32'd0);
    run_table(898);
    check("done_after_death", 32'(encounter_done), 32'd1);
    run_table(910);
    check("done_is_terminal", 32'(encounter_done), 32'd1);

    // Enable held low for 20 frames mid-cooldown: the FAN slides by exactly 20 frames.
    do_reset(3);
    load_intro_rows();
    run_table(100);
    repeat (20) step(1'b0, 8'h00, 1'b0);
    run_table(250);

    // Reset mid-SWEEP, then the INTRO restart timing matches a fresh start.
    do_reset(1);
    add(60,  1, 0, 8'h00, 0, 1);
    add(61,  1, 0, 8'h00, 0, 2);
    add(106, 1, 0, 8'hFF, 1, 2);
    add(151, 1, 0, 8'h55, 1, 2);
    add(157, 1, 0, 8'hAA, 0, 2);
    add(202, 1, 0, 8'h01, 1, 2);
    add(208, 1, 0, 8'h02, 0, 2);
    add(214, 1, 0, 8'h04, 0, 2);
    run_table(214);
    check("busy_before_reset", 32'(attack_busy), 32'd1);
    do_reset(3);
    load_intro_rows();
    run_table(250);

    // 2000-frame NORMAL run: one direction_switch per attack.
    do_reset(3);
    add(60, 3, 0, 8'h00, 0, 1);
    exp_attacks = 0;
    for (int k = 0; k < 12; k++) begin
      if (150 + 186 * k <= 2000) begin
        add(150 + 186 * k, 3, 0, 8'hFF, 1, 1);
        exp_attacks++;
      end
      if (246 + 186 * k <= 2000) begin
        add(240 + 186 * k, 3, 0, 8'h55, 1, 1);
        add(246 + 186 * k, 3, 0, 8'hAA, 0, 1);
        exp_attacks++;
      end
    end
    dir_seen = 0;
    run_table(2000);
    check("attack_count", 32'(dir_seen), 32'(exp_attacks));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
